// File: rtl/led_status_ctrl.sv
// led_status_ctrl: NCH-channel status LED driver sharing one prescaler tick.
// Optional per-channel error-code flasher compiled in with `define LED_CODE_EN.
module led_status_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 10,
    parameter int NCH       = 2,
    parameter int CODE_W    = 4,
    parameter int GAP_TICKS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync_clr,
    input  logic [2*NCH-1:0]       mode,
    input  logic [CODE_W*NCH-1:0]  code,
    output logic                   tick_o,
    output logic [NCH-1:0]         led_n
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;

    logic [PW-1:0]  ps_q, ps_d;
    logic           phase_q, phase_d;
    logic           tick_q;
    logic           tick;
    logic [NCH-1:0] led_n_q, led_n_d;

    // sync_clr wins over a coincident tick, so the tick is masked here
    assign tick = (ps_q == PS_LAST) && !sync_clr;

    always_comb begin
        ps_d    = ps_q;
        phase_d = phase_q;
        if (sync_clr) begin
            ps_d    = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            ps_d    = '0;
            phase_d = ~phase_q;
        end else begin
            ps_d = ps_q + PW'(1);
        end
    end

`ifdef LED_CODE_EN
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [1:0] M_CODE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_P_ON  = 2'd1,
        S_P_OFF = 2'd2,
        S_GAP   = 2'd3
    } code_st_e;

    code_st_e          st_q  [NCH];
    code_st_e          st_d  [NCH];
    logic [CODE_W-1:0] cnt_q [NCH];
    logic [CODE_W-1:0] cnt_d [NCH];
    logic [GW-1:0]     gap_q [NCH];
    logic [GW-1:0]     gap_d [NCH];
    logic [NCH-1:0]    code_lit;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]     = st_q[i];
            cnt_d[i]    = cnt_q[i];
            gap_d[i]    = gap_q[i];
            code_lit[i] = (st_q[i] == S_P_ON);
            if (sync_clr || (mode[2*i +: 2] != M_CODE)) begin
                st_d[i] = S_IDLE;
            end else if (tick) begin
                unique case (st_q[i])
                    S_IDLE: begin
                        cnt_d[i] = code[CODE_W*i +: CODE_W];
                        if (code[CODE_W*i +: CODE_W] != '0) begin
                            st_d[i] = S_P_ON;
                        end else begin
                            st_d[i]  = S_GAP;
                            gap_d[i] = GAP_LAST;
                        end
                    end
                    S_P_ON: begin
                        cnt_d[i] = cnt_q[i] - CODE_W'(1);
                        st_d[i]  = S_P_OFF;
                    end
                    S_P_OFF: begin
                        if (cnt_q[i] != '0) begin
                            st_d[i] = S_P_ON;
                        end else begin
                            st_d[i]  = S_GAP;
                            gap_d[i] = GAP_LAST;
                        end
                    end
                    S_GAP: begin
                        if (gap_q[i] == '0) begin
                            cnt_d[i] = code[CODE_W*i +: CODE_W];
                            if (code[CODE_W*i +: CODE_W] != '0) begin
                                st_d[i] = S_P_ON;
                            end else begin
                                gap_d[i] = GAP_LAST;
                            end
                        end else begin
                            gap_d[i] = gap_q[i] - GW'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
                gap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                gap_q[i] <= gap_d[i];
            end
        end
    end
`else
    // code input is kept on the port but has no function in this build
    logic unused_code;
    assign unused_code = ^code;
`endif

    always_comb begin
        led_n_d = '1;
        for (int i = 0; i < NCH; i++) begin
            case (mode[2*i +: 2])
                M_OFF:   led_n_d[i] = 1'b1;
                M_ON:    led_n_d[i] = 1'b0;
                M_BLINK: led_n_d[i] = ~phase_q;
`ifdef LED_CODE_EN
                default: led_n_d[i] = ~code_lit[i];
`else
                default: led_n_d[i] = ~phase_q;
`endif
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q    <= '0;
            phase_q <= 1'b0;
            tick_q  <= 1'b0;
            led_n_q <= '1;
        end else begin
            ps_q    <= ps_d;
            phase_q <= phase_d;
            tick_q  <= tick;
            led_n_q <= led_n_d;
        end
    end

    assign tick_o = tick_q;
    assign led_n  = led_n_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl: CLK_HZ=100, TICK_HZ=10 (tick every 10 clk).
module tb_led_status_ctrl;
    logic       clk;
    logic       rst_n;
    logic       sync_clr;
    logic [3:0] mode;
    logic [7:0] code;
    logic       tick_o;
    logic [1:0] led_n;

    int total = 0;
    int bad   = 0;

    led_status_ctrl #(
        .CLK_HZ(100), .TICK_HZ(10), .NCH(2), .CODE_W(4), .GAP_TICKS(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .mode(mode), .code(code), .tick_o(tick_o), .led_n(led_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle sync_clr; the edge it lands on is reference edge k=0
    task automatic clr_sync();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic exp_t;
        rst_n = 1'b0; sync_clr = 1'b0; mode = '0; code = '0;
        repeat (3) step();
        total++;
        if (led_n !== 2'b11) begin
            bad++; $display("FAIL reset_led got=%b exp=11", led_n);
        end
        total++;
        if (tick_o !== 1'b0) begin
            bad++; $display("FAIL reset_tick got=%b exp=0", tick_o);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_t = (k % 10 == 0);
            total++;
            if (tick_o !== exp_t) begin
                bad++; $display("FAIL reset_tick_period k=%0d got=%b exp=%b", k, tick_o, exp_t);
            end
        end
    endtask

    task automatic test_static();
        logic [3:0] m [4];
        logic [1:0] e [4];
        m[0] = 4'b0100; e[0] = 2'b01;
        m[1] = 4'b0001; e[1] = 2'b10;
        m[2] = 4'b0101; e[2] = 2'b00;
        m[3] = 4'b0000; e[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            mode = m[i];
            step();
            total++;
            if (led_n !== e[i]) begin
                bad++; $display("FAIL static i=%0d got=%b exp=%b", i, led_n, e[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic lit;
        logic [1:0] exp_l;
        mode = 4'b0110;
        clr_sync();
        for (int k = 1; k <= 40; k++) begin
            step();
            lit = (((k - 1) / 10) % 2) == 1;
            exp_l = {1'b0, !lit};
            total++;
            if (led_n !== exp_l) begin
                bad++; $display("FAIL blink k=%0d got=%b exp=%b", k, led_n, exp_l);
            end
        end
    endtask

    task automatic test_sync_clr();
        logic exp_t;
        logic lit;
        mode = 4'b1110; code = {4'd1, 4'd0};
        clr_sync();
        for (int k = 1; k <= 19; k++) begin
            step();
            exp_t = (k == 10);
            total++;
            if (tick_o !== exp_t) begin
                bad++; $display("FAIL pre_clr_tick k=%0d got=%b exp=%b", k, tick_o, exp_t);
            end
        end
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        total++;
        if (tick_o !== 1'b0) begin
            bad++; $display("FAIL clr_tick_suppressed got=%b exp=0", tick_o);
        end
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_t = (k == 10);
            lit = (k == 11);
            total++;
            if (tick_o !== exp_t) begin
                bad++; $display("FAIL post_clr_tick k=%0d got=%b exp=%b", k, tick_o, exp_t);
            end
            total++;
            if (led_n !== {!lit, !lit}) begin
                bad++; $display("FAIL post_clr_led k=%0d got=%b exp=%b", k, led_n, {!lit, !lit});
            end
        end
    endtask

`ifndef LED_CODE_EN
    task automatic test_mode3_as_blink();
        logic lit;
        logic [1:0] exp_l;
        mode = 4'b1011; code = {4'd5, 4'd3};
        clr_sync();
        for (int k = 1; k <= 40; k++) begin
            step();
            lit = (((k - 1) / 10) % 2) == 1;
            exp_l = {!lit, !lit};
            total++;
            if (led_n !== exp_l) begin
                bad++; $display("FAIL mode3_blink k=%0d got=%b exp=%b", k, led_n, exp_l);
            end
        end
    endtask
`else
    task automatic test_code();
        int j, r;
        logic lit;
        code = {4'd0, 4'd3}; mode = 4'b0011;
        clr_sync();
        for (int k = 1; k <= 250; k++) begin
            step();
            j = (k - 1) / 10;
            r = (j - 1) % 12;
            lit = (j >= 1) && (r == 0 || r == 2 || r == 4);
            total++;
            if (led_n !== {1'b1, !lit}) begin
                bad++; $display("FAIL code3 k=%0d got=%b exp=%b", k, led_n, {1'b1, !lit});
            end
        end
    endtask

    task automatic test_code_change();
        int j;
        logic lit;
        code = {4'd0, 4'd3}; mode = 4'b0011;
        clr_sync();
        for (int k = 1; k <= 220; k++) begin
            step();
            j = (k - 1) / 10;
            lit = (j == 1 || j == 3 || j == 5) || (j >= 13 && ((j - 13) % 8) == 0);
            total++;
            if (led_n !== {1'b1, !lit}) begin
                bad++; $display("FAIL code_change k=%0d got=%b exp=%b", k, led_n, {1'b1, !lit});
            end
            if (k == 35) code = {4'd0, 4'd1};
        end
        code = {4'd0, 4'd0};
        clr_sync();
        for (int k = 1; k <= 200; k++) begin
            step();
            total++;
            if (led_n !== 2'b11) begin
                bad++; $display("FAIL code_zero k=%0d got=%b exp=11", k, led_n);
            end
        end
    endtask

    task automatic test_leave_reenter();
        logic lit;
        code = {4'd0, 4'd2}; mode = 4'b0011;
        clr_sync();
        for (int k = 1; k <= 31; k++) begin
            step();
            lit = (k >= 11 && k <= 15) || (k >= 21 && k <= 30);
            total++;
            if (led_n !== {1'b1, !lit}) begin
                bad++; $display("FAIL leave_reenter k=%0d got=%b exp=%b", k, led_n, {1'b1, !lit});
            end
            if (k == 15) mode = 4'b0000;
            if (k == 16) mode = 4'b0011;
        end
    endtask
`endif

    task automatic test_async_reset();
        mode = 4'b0101;
        step();
        step();
        total++;
        if (led_n !== 2'b00) begin
            bad++; $display("FAIL pre_async_led got=%b exp=00", led_n);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if (led_n !== 2'b11) begin
            bad++; $display("FAIL async_led got=%b exp=11", led_n);
        end
        total++;
        if (tick_o !== 1'b0) begin
            bad++; $display("FAIL async_tick got=%b exp=0", tick_o);
        end
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (led_n !== 2'b00) begin
            bad++; $display("FAIL post_async_led got=%b exp=00", led_n);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_sync_clr();
`ifndef LED_CODE_EN
        test_mode3_as_blink();
`else
        test_code();
        test_code_change();
        test_leave_reenter();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
